// File: rtl/coin_credit_fsm.sv
// Soda-machine front end: collects coins into a credit register, vends once the external
// comparator reports credit >= price, then pays change out one unit per cycle or refunds on cancel.
module coin_credit_fsm #(
  parameter int WIDTH       = 8,
  parameter int NICKEL_VAL  = 5,
  parameter int DIME_VAL    = 10,
  parameter int QUARTER_VAL = 25,
  parameter int CHANGE_UNIT = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             coin_valid,
  input  logic [1:0]       coin_type,
  input  logic             cancel,
  input  logic [WIDTH-1:0] price,
  input  logic             credit_lt,
  output logic [WIDTH-1:0] credit,
  output logic             dispense,
  output logic             change_pulse,
  output logic             coin_reject,
  output logic             busy
);

  // state    | meaning
  // IDLE     | credit is zero, waiting for the first coin
  // COLLECT  | accumulating coins until credit reaches price or cancel
  // DISPENSE | one-cycle vend pulse, price deducted on exit
  // CHANGE   | paying out remaining credit one unit per cycle
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COLLECT  = 2'd1,
    S_DISPENSE = 2'd2,
    S_CHANGE   = 2'd3
  } state_t;

  localparam logic [WIDTH:0]   LP_NICKEL  = (WIDTH+1)'(NICKEL_VAL);
  localparam logic [WIDTH:0]   LP_DIME    = (WIDTH+1)'(DIME_VAL);
  localparam logic [WIDTH:0]   LP_QUARTER = (WIDTH+1)'(QUARTER_VAL);
  localparam logic [WIDTH:0]   LP_MAX     = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH-1:0] LP_UNIT    = WIDTH'(CHANGE_UNIT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_credit;
  logic [WIDTH-1:0] w_credit_nxt;
  logic             r_coin_reject;

  logic [WIDTH:0]   w_coin_val;
  logic [WIDTH:0]   w_sum;
  logic             w_coin_legal;
  logic             w_coin_window;
  logic             w_coin_accept;
  logic [WIDTH-1:0] w_after_vend;
  logic [WIDTH-1:0] w_after_change;
  logic             w_has_unit;

  always_comb begin
    w_coin_val = '0;
    case (coin_type)
      2'b00:   w_coin_val = LP_NICKEL;
      2'b01:   w_coin_val = LP_DIME;
      2'b10:   w_coin_val = LP_QUARTER;
      default: w_coin_val = '0;
    endcase
  end

  // Sum is one bit wider so an overflowing coin is refused rather than wrapping.
  assign w_sum         = {1'b0, r_credit} + w_coin_val;
  assign w_coin_legal  = (coin_type != 2'b11);
  assign w_coin_window = (r_state == S_IDLE) ||
                         ((r_state == S_COLLECT) && credit_lt && !cancel);
  assign w_coin_accept = coin_valid && w_coin_legal && w_coin_window && (w_sum <= LP_MAX);

  // Price may have moved above credit by the time we vend; clamp instead of wrapping.
  assign w_after_vend   = (r_credit >= price) ? (r_credit - price) : '0;
  assign w_has_unit     = (r_credit >= LP_UNIT);
  assign w_after_change = r_credit - LP_UNIT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_credit      <= '0;
      r_coin_reject <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_credit      <= w_credit_nxt;
      r_coin_reject <= coin_valid && !w_coin_accept;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    case (r_state)
      S_IDLE: begin
        if (w_coin_accept) begin
          w_state_nxt  = S_COLLECT;
          w_credit_nxt = w_sum[WIDTH-1:0];
        end
      end
      S_COLLECT: begin
        if (!credit_lt) begin
          w_state_nxt = S_DISPENSE;
        end else if (cancel) begin
          w_state_nxt = S_CHANGE;
        end else if (w_coin_accept) begin
          w_credit_nxt = w_sum[WIDTH-1:0];
        end
      end
      S_DISPENSE: begin
        w_credit_nxt = w_after_vend;
        w_state_nxt  = (w_after_vend != '0) ? S_CHANGE : S_IDLE;
      end
      S_CHANGE: begin
        if (w_has_unit) begin
          w_credit_nxt = w_after_change;
        end else begin
          w_credit_nxt = '0;
          w_state_nxt  = S_IDLE;
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_credit_nxt = '0;
      end
    endcase
  end

  always_comb begin
    dispense     = (r_state == S_DISPENSE);
    change_pulse = (r_state == S_CHANGE) && w_has_unit;
    busy         = (r_state == S_DISPENSE) || (r_state == S_CHANGE);
  end

  assign credit      = r_credit;
  assign coin_reject = r_coin_reject;

endmodule

// File: tb/tb_coin_credit_fsm.sv
// Directed bench for coin_credit_fsm: an 8-bit instance for the vend/change/cancel/reset flows
// and a 5-bit instance for overflow rejection; the price comparator is modelled here.
module tb_coin_credit_fsm;

  logic       clk;
  logic       rst_n;

  logic       a_coin_valid, a_cancel;
  logic [1:0] a_coin_type;
  logic [7:0] a_price, a_credit;
  logic       a_lt, a_dispense, a_change, a_reject, a_busy;

  logic       b_coin_valid, b_cancel;
  logic [1:0] b_coin_type;
  logic [4:0] b_price, b_credit;
  logic       b_lt, b_dispense, b_change, b_reject, b_busy;

  int n_chk = 0;
  int n_bad = 0;

  localparam logic [1:0] NICKEL  = 2'b00;
  localparam logic [1:0] DIME    = 2'b01;
  localparam logic [1:0] QUARTER = 2'b10;
  localparam logic [1:0] SLUG    = 2'b11;

  assign a_lt = (a_credit < a_price);
  assign b_lt = (b_credit < b_price);

  coin_credit_fsm #(.WIDTH(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .coin_valid(a_coin_valid), .coin_type(a_coin_type),
    .cancel(a_cancel), .price(a_price), .credit_lt(a_lt), .credit(a_credit),
    .dispense(a_dispense), .change_pulse(a_change), .coin_reject(a_reject), .busy(a_busy)
  );

  coin_credit_fsm #(.WIDTH(5)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .coin_valid(b_coin_valid), .coin_type(b_coin_type),
    .cancel(b_cancel), .price(b_price), .credit_lt(b_lt), .credit(b_credit),
    .dispense(b_dispense), .change_pulse(b_change), .coin_reject(b_reject), .busy(b_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_coin(input logic [1:0] t);
    a_coin_valid = 1'b1;
    a_coin_type  = t;
    tick();
    a_coin_valid = 1'b0;
  endtask

  task automatic b_coin(input logic [1:0] t);
    b_coin_valid = 1'b1;
    b_coin_type  = t;
    tick();
    b_coin_valid = 1'b0;
  endtask

  // Run instance A until it leaves DISPENSE/CHANGE, counting pulses; bounded.
  task automatic a_drain(output int np, output int nd);
    bit done;
    np   = 0;
    nd   = 0;
    done = 0;
    for (int i = 0; i < 16; i++) begin
      if (!a_busy) begin
        done = 1;
        break;
      end
      np += int'(a_change);
      nd += int'(a_dispense);
      tick();
    end
    chk("drain_done", int'(done), 1);
  endtask

  initial begin
    int np, nd;
    rst_n = 1'b0;
    a_coin_valid = 0; a_cancel = 0; a_coin_type = NICKEL; a_price = 8'd35;
    b_coin_valid = 0; b_cancel = 0; b_coin_type = NICKEL; b_price = 5'd31;
    tick(); tick();
    chk("rst_credit", a_credit, 0);
    chk("rst_dispense", a_dispense, 0);
    chk("rst_change", a_change, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_reject", a_reject, 0);
    rst_n = 1'b1;
    tick();

    // 1: exact payment
    a_price = 8'd35;
    a_coin(QUARTER);
    chk("t1_credit25", a_credit, 25);
    a_coin(DIME);
    chk("t1_credit35", a_credit, 35);
    chk("t1_no_disp_yet", a_dispense, 0);
    tick();
    chk("t1_dispense", a_dispense, 1);
    chk("t1_busy", a_busy, 1);
    tick();
    chk("t1_disp_once", a_dispense, 0);
    chk("t1_credit0", a_credit, 0);
    chk("t1_no_change", a_change, 0);
    chk("t1_idle", a_busy, 0);

    // 2: overpay, 15 cents back
    a_coin(QUARTER);
    a_coin(QUARTER);
    chk("t2_credit50", a_credit, 50);
    tick();
    chk("t2_dispense", a_dispense, 1);
    tick();
    chk("t2_credit15", a_credit, 15);
    chk("t2_pulse1", a_change, 1);
    tick();
    chk("t2_pulse2", a_change, 1);
    tick();
    chk("t2_pulse3", a_change, 1);
    chk("t2_credit5", a_credit, 5);
    tick();
    chk("t2_no_pulse4", a_change, 0);
    chk("t2_credit_end", a_credit, 0);
    tick();
    chk("t2_idle", a_busy, 0);

    // 3: cancel refunds
    a_price = 8'd50;
    a_coin(DIME);
    a_coin(NICKEL);
    chk("t3_credit15", a_credit, 15);
    a_cancel = 1'b1;
    tick();
    a_cancel = 1'b0;
    a_drain(np, nd);
    chk("t3_pulses", np, 3);
    chk("t3_no_dispense", nd, 0);
    chk("t3_credit0", a_credit, 0);

    // slug in IDLE
    a_coin(SLUG);
    chk("slug_reject", a_reject, 1);
    chk("slug_credit", a_credit, 0);
    tick();
    chk("slug_reject_pulse", a_reject, 0);

    // 4: 5-bit overflow rejection
    b_coin(QUARTER);
    chk("t4_credit25", b_credit, 25);
    chk("t4_q_ok", b_reject, 0);
    b_coin(DIME);
    chk("t4_dime_reject", b_reject, 1);
    chk("t4_credit_kept", b_credit, 25);
    tick();
    chk("t4_reject_1cyc", b_reject, 0);
    b_coin(SLUG);
    chk("t4_slug_reject", b_reject, 1);
    chk("t4_credit_kept2", b_credit, 25);
    b_coin(NICKEL);
    chk("t4_nickel_ok", b_reject, 0);
    chk("t4_credit30", b_credit, 30);
    b_cancel = 1'b1;
    tick();
    b_cancel = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("t4_refund_done", b_credit, 0);
    chk("t4_idle", b_busy, 0);

    // 5: threshold beats cancel and coin
    a_price = 8'd10;
    a_coin(DIME);
    chk("t5_credit10", a_credit, 10);
    a_coin_valid = 1'b1;
    a_coin_type  = NICKEL;
    a_cancel     = 1'b1;
    tick();
    chk("t5_dispense", a_dispense, 1);
    chk("t5_reject", a_reject, 1);
    chk("t5_credit_kept", a_credit, 10);
    a_cancel = 1'b0;
    tick();
    a_coin_valid = 1'b0;
    chk("t5_reject_in_disp", a_reject, 1);
    chk("t5_credit0", a_credit, 0);
    chk("t5_idle", a_busy, 0);
    chk("t5_no_change", a_change, 0);

    // 6: async reset in the middle of change payout
    a_price = 8'd35;
    a_coin(QUARTER);
    a_coin(QUARTER);
    a_coin(QUARTER);
    chk("t6_3rd_reject", a_reject, 1);
    chk("t6_dispense", a_dispense, 1);
    tick();
    chk("t6_pulse1", a_change, 1);
    tick();
    chk("t6_pulse2", a_change, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_credit", a_credit, 0);
    chk("t6_async_change", a_change, 0);
    chk("t6_async_busy", a_busy, 0);
    chk("t6_async_disp", a_dispense, 0);
    tick();
    rst_n = 1'b1;
    np = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      np += int'(a_change);
    end
    chk("t6_no_more_pulses", np, 0);
    chk("t6_credit_end", a_credit, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
